lamp_seq_ctrl: RTL and testbench
================================

# lamp_seq_ctrl

Sequential controller for the three-switch stairwell lamp: synchronizes and debounces wall switches S1..S3, and turns each debounced switch flip into one lamp toggle (XOR semantics). It optionally adds an auto-off timer with a pre-off warning. It sits between the raw board switches and the lamp LED, and replaces direct combinational drive of F.

## Interface
- DB_CYCLES, 4: consecutive stable cycles required before a switch level is accepted (≥2).
- TIMEOUT, 64: cycles the lamp stays on before auto-off (≥ WARN_CYCLES+2).
- WARN_CYCLES, 16: length of the warning window at the end of TIMEOUT.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- S1, S2, S3  in  1 each  raw switch levels, asynchronous to clk.
- F  out  1  lamp drive.
- warn  out  1  high while in WARN.
- auto_off  out  1  one-cycle pulse when the timer switches the lamp off.
- state  out  2  INIT=00, OFF=01, ON=10, WARN=11.

## Operation
- Per switch: 2-flop synchronizer (sync1→sync2), a debounced level `stable`, and a counter `cnt` of width clog2(DB_CYCLES).
- When sync2≠stable, cnt increments each cycle. When sync2==stable, cnt clears. When sync2≠stable and cnt==DB_CYCLES-1, stable takes sync2, cnt clears, and a change event fires for that switch in the same cycle.
- Toggle request = XOR of the three change events. Two simultaneous flips cancel; three flips toggle once.
- FSM:
  - INIT: lasts 3 edges after reset release. On the 3rd edge, every stable loads sync2 directly with no events, and the FSM goes to OFF.
  - OFF: toggle request → ON, timer cleared to 0.
  - ON: toggle → OFF. Timer reaches TIMEOUT-WARN_CYCLES-1 → WARN.
  - WARN: toggle → OFF with no auto_off pulse. Timer reaches TIMEOUT-1 → OFF with auto_off=1 for that cycle.
- F=1 in ON and WARN, 0 otherwise. warn=1 only in WARN.
- Timer: clog2(TIMEOUT) bits, increments in ON and WARN, clears on entry to OFF or ON. It never wraps, because the WARN exit happens first.
- A toggle request and the timeout in the same cycle give OFF; auto_off is not pulsed because the user event has priority.
- Switch events in INIT are discarded. A switch held high through reset does not light the lamp.

## Timing
- Reset values: F=0, warn=0, auto_off=0, state=00. All sync, stable, cnt and timer registers are 0.
- Reset mid-operation: all outputs drop immediately (asynchronous). The block re-runs INIT after release.
- Latency: a new switch level first sampled by sync1 at edge n changes F at edge n+DB_CYCLES+1. A glitch shorter than DB_CYCLES cycles (after sync) produces no event.
- Lamp on-time without user action is exactly TIMEOUT cycles: F rises at edge m and falls at edge m+TIMEOUT. warn is high during the final WARN_CYCLES cycles.
- auto_off is registered and coincides with the first cycle of F=0.

## Configuration
- Macro LAMP_SEQ_AUTO_OFF_EN.
- Defined: the timer, WARN state and auto_off behave as above.
- Undefined: no timer is built. The FSM uses only INIT/OFF/ON, and ON exits only on a toggle. warn and auto_off are tied to 0, and F is pure debounced parity from OFF.

## Test plan
- Reset with S3=1 held, release, wait 20 cycles → state=01, F=0, no toggle.
- From OFF, set S1 0→1 → F=1 at exactly DB_CYCLES+1=5 edges after sync1 samples it; state=10.
- Pulse S2 high for 3 cycles (< DB_CYCLES) → F unchanged, no event.
- Flip S1 and S2 in the same cycle → F unchanged. Then flip S1, S2 and S3 together → F toggles once.
- With macro defined, lamp on and idle → warn rises 48 cycles after F rises. F falls and auto_off pulses for one cycle at 64 cycles. state goes 10→11→01.
- Assert rst while in WARN → F, warn and state clear immediately. After release, 3 cycles of INIT, then OFF. With macro undefined, lamp on for 200 cycles stays F=1.

Source files
------------

// File: rtl/lamp_seq_ctrl.sv
// lamp_seq_ctrl: debounced three-switch stairwell lamp controller with optional auto-off timer
//   clk, rst         : clock, asynchronous active-high reset
//   S1, S2, S3       : raw switch levels (asynchronous to clk)
//   F                : lamp drive
//   warn             : high while the pre-off warning window is active
//   auto_off         : one-cycle pulse when the timer switched the lamp off
//   state            : INIT=00, OFF=01, ON=10, WARN=11
//   LAMP_SEQ_AUTO_OFF_EN : when defined, builds the timer, WARN state and auto_off
module lamp_seq_ctrl #(
    parameter int DB_CYCLES   = 4,
    parameter int TIMEOUT     = 64,
    parameter int WARN_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    output logic       F,
    output logic       warn,
    output logic       auto_off,
    output logic [1:0] state
);
    typedef enum logic [1:0] {INIT = 2'b00, OFF = 2'b01, ON = 2'b10, WARN = 2'b11} state_t;
    localparam int CW = $clog2(DB_CYCLES);
    state_t        state_q, state_d;
    logic [2:0]    sync1_q, sync2_q, stable_q, stable_d, evt;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [1:0]    init_q;
    logic          init_done, toggle;
    assign init_done = (state_q == INIT) && (init_q == 2'd2);
    assign toggle    = ^evt;
    // Debouncers are frozen during INIT; the last INIT edge adopts the synced levels without events.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            evt[i]      = 1'b0;
            stable_d[i] = init_done ? sync2_q[i] : stable_q[i];
            cnt_d[i]    = '0;
            if (state_q != INIT && sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                    evt[i]      = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end
`ifdef LAMP_SEQ_AUTO_OFF_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] timer_q, timer_d;
    logic          auto_off_q, auto_off_d;
    logic          warn_hit, time_up;
    assign warn_hit = timer_q == TW'(TIMEOUT - WARN_CYCLES - 1);
    assign time_up  = timer_q == TW'(TIMEOUT - 1);
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = init_done ? OFF : INIT;
            OFF:     state_d = toggle ? ON : OFF;
            ON:      state_d = toggle ? OFF : (warn_hit ? WARN : ON);
            default: state_d = (toggle || time_up) ? OFF : WARN;
        endcase
        // Counting continues across ON->WARN; any entry to OFF or ON restarts from zero.
        timer_d    = (state_q[1] && state_d != OFF) ? timer_q + 1'b1 : '0;
        auto_off_d = (state_q == WARN) && time_up && !toggle;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q    <= '0;
            auto_off_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            auto_off_q <= auto_off_d;
        end
    end
    assign warn     = state_q == WARN;
    assign auto_off = auto_off_q;
`else
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = init_done ? OFF : INIT;
            OFF:     state_d = toggle ? ON : OFF;
            ON:      state_d = toggle ? OFF : ON;
            default: state_d = OFF;
        endcase
    end
    assign warn     = 1'b0;
    assign auto_off = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '{default: '0};
            init_q   <= '0;
            state_q  <= INIT;
        end else begin
            sync1_q  <= {S3, S2, S1};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            init_q   <= (state_q == INIT) ? init_q + 2'd1 : init_q;
            state_q  <= state_d;
        end
    end
    assign F     = state_q[1];
    assign state = state_q;
endmodule

// File: tb/tb_lamp_seq_ctrl.sv
// tb_lamp_seq_ctrl: randomized and directed bench for lamp_seq_ctrl against a lamp-level reference model
module tb_lamp_seq_ctrl;
    localparam int DB = 4;
    localparam int TO = 64;
    localparam int WC = 16;
`ifdef LAMP_SEQ_AUTO_OFF_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       S1 = 1'b0, S2 = 1'b0, S3 = 1'b0;
    logic       F, warn, auto_off;
    logic [1:0] state;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [2:0] hist [0:16383];
    int         e;
    logic [2:0] m_stable;
    bit         m_init, m_on, m_auto;
    int         m_age;
    lamp_seq_ctrl #(.DB_CYCLES(DB), .TIMEOUT(TO), .WARN_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .S1(S1), .S2(S2), .S3(S3),
        .F(F), .warn(warn), .auto_off(auto_off), .state(state)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, e, $time);
    endtask
    task automatic model_reset();
        e = 0; m_init = 1; m_on = 0; m_auto = 0; m_age = 0; m_stable = '0;
    endtask
    // A switch level is accepted once it has been seen (two edges late) on DB consecutive
    // post-INIT samples; the lamp follows the parity of accepted flips and times out after TO edges on.
    task automatic model_edge(input logic [2:0] s);
        bit tog, run;
        e++;
        hist[e] = s;
        m_auto = 0;
        if (e == 3) begin
            m_stable = hist[2];
            m_init = 0;
        end else if (e > 3) begin
            tog = 0;
            for (int sw = 0; sw < 3; sw++) begin
                run = (e >= DB + 3);
                if (run)
                    for (int j = 0; j < DB; j++)
                        if (hist[e-2-j][sw] == m_stable[sw]) run = 0;
                if (run) begin
                    m_stable[sw] = ~m_stable[sw];
                    tog = ~tog;
                end
            end
            if (tog) begin
                m_age = 0;
                m_on = ~m_on;
            end else if (AUTO && m_on) begin
                m_age++;
                if (m_age == TO) begin
                    m_on = 0;
                    m_auto = 1;
                end
            end
        end
    endtask
    function automatic int exp_state();
        return m_init ? 0 : !m_on ? 1 : (AUTO && m_age >= TO - WC) ? 3 : 2;
    endfunction
    task automatic step(input logic [2:0] s);
        {S3, S2, S1} = s;
        @(posedge clk);
        model_edge(s);
        #1;
        chk("F", int'(F), int'(m_on));
        chk("warn", int'(warn), int'(AUTO && m_on && m_age >= TO - WC));
        chk("auto_off", int'(auto_off), int'(m_auto));
        chk("state", int'(state), exp_state());
        @(negedge clk);
    endtask
    task automatic hold(input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) step(s);
    endtask
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_F", int'(F), 0);
        chk("rst_warn", int'(warn), 0);
        chk("rst_auto_off", int'(auto_off), 0);
        chk("rst_state", int'(state), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask
    initial begin
        int set_e, rise_e, warn_e, fall_e, pulses;
        logic [2:0] s;
        model_reset();
        {S3, S2, S1} = 3'b100;
        repeat (3) @(negedge clk);
        chk("reset_F", int'(F), 0);
        chk("reset_state", int'(state), 0);
        chk("reset_warn", int'(warn), 0);
        chk("reset_auto_off", int'(auto_off), 0);
        rst = 1'b0;
        hold(3'b100, 20);
        chk("s3_held_off", int'(state), 1);
        set_e = e + 1;
        rise_e = 0;
        for (int i = 0; i < 10; i++) begin
            step(3'b101);
            if (F && rise_e == 0) rise_e = e;
        end
        chk("on_latency", rise_e, set_e + DB + 1);
        hold(3'b111, 3);
        hold(3'b101, 10);
        chk("glitch_ignored", int'(F), 1);
        hold(3'b110, 10);
        chk("two_flip_cancel", int'(F), 1);
        hold(3'b001, 10);
        chk("three_flip_toggle", int'(F), 0);
        if (AUTO) begin
            rise_e = 0; warn_e = 0; fall_e = 0; pulses = 0;
            for (int i = 0; i < 90; i++) begin
                step(3'b000);
                if (F && rise_e == 0) rise_e = e;
                if (warn && warn_e == 0) warn_e = e;
                if (!F && rise_e != 0 && fall_e == 0) fall_e = e;
                if (auto_off) pulses++;
            end
            chk("warn_after_on", warn_e - rise_e, TO - WC);
            chk("off_after_on", fall_e - rise_e, TO);
            chk("auto_off_pulses", pulses, 1);
            hold(3'b001, 55);
            chk("in_warn", int'(state), 3);
        end else begin
            hold(3'b000, 200);
            chk("stays_on", int'(F), 1);
        end
        async_reset();
        hold(3'b001, 3);
        chk("init_then_off", int'(state), 1);
        s = 3'b001;
        for (int k = 0; k < 300; k++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(3) == 0) s[b] = ~s[b];
            hold(s, ($urandom_range(9) == 0) ? 70 : $urandom_range(1, 12));
            if (k == 150) begin
                async_reset();
                hold(s, 5);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
